// File: rtl/ofifo.sv
// ofifo: bank of per-column FIFOs that re-aligns skewed column writes into full rows.
// Optional sticky overflow/underflow flags are built when OFIFO_STICKY_ERR_EN is defined.
module ofifo #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col-1:0]         wr,
   input  logic [psum_bw*col-1:0] in,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_full,
   output logic                   o_ready,
`ifdef OFIFO_STICKY_ERR_EN
   output logic [col-1:0]         o_ovf,
   output logic                   o_udf,
`endif
   output logic                   o_valid
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [col-1:0] full;
   logic [col-1:0] empty;
   logic [col-1:0] wr_acc;
   logic           rd_acc;

   // row-level handshake: a row pops only when every column has a head,
   // and a full column still takes a write when the same edge pops it
   always_comb begin
      o_valid = &(~empty);
      o_full  = |full;
      o_ready = ~o_full;
      rd_acc  = rd & o_valid;
      wr_acc  = wr & (~full | {col{rd_acc}});
   end

   for (genvar k = 0; k < col; k++) begin : g_col
      logic [AW:0]        wptr;
      logic [AW:0]        rptr;
      logic [psum_bw-1:0] mem [depth];

      assign empty[k] = (wptr == rptr);
      assign full[k]  = (wptr[AW] != rptr[AW]) &&
                        (wptr[AW-1:0] == rptr[AW-1:0]);

      // pointers; all read pointers step on the same shared rd_acc
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr_acc[k]) wptr <= wptr + PTR_ONE;
            if (rd_acc)    rptr <= rptr + PTR_ONE;
         end
      end

      // storage is never reset; stale words are masked by the empty check
      always_ff @(posedge clk) begin
         if (wr_acc[k]) mem[wptr[AW-1:0]] <= in[k*psum_bw +: psum_bw];
      end

      assign out[k*psum_bw +: psum_bw] =
         empty[k] ? '0 : mem[rptr[AW-1:0]];
   end

`ifdef OFIFO_STICKY_ERR_EN
   // sticky error capture: dropped writes per column, reads while not valid
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_ovf <= '0;
         o_udf <= 1'b0;
      end else begin
         o_ovf <= o_ovf | (wr & ~wr_acc);
         o_udf <= o_udf | (rd & ~o_valid);
      end
   end
`endif

endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo: vector table, directed corner sequences and a random stream
// checked against a queue-based model of the column FIFO bank.
module tb_ofifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 4;
   localparam int W     = COL*BW;

   logic           clk = 1'b0;
   logic           reset;
   logic [COL-1:0] wr;
   logic [W-1:0]   in;
   logic           rd;
   logic [W-1:0]   out;
   logic           o_full;
   logic           o_ready;
   logic           o_valid;
`ifdef OFIFO_STICKY_ERR_EN
   logic [COL-1:0] o_ovf;
   logic           o_udf;
`endif

   always #5 clk = ~clk;

   ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .in      (in),
      .rd      (rd),
      .out     (out),
      .o_full  (o_full),
      .o_ready (o_ready),
`ifdef OFIFO_STICKY_ERR_EN
      .o_ovf   (o_ovf),
      .o_udf   (o_udf),
`endif
      .o_valid (o_valid)
   );

   int errors = 0;
   int checks = 0;

   logic [BW-1:0]  q [COL][$];
   logic [COL-1:0] m_ovf;
   logic           m_udf;

   typedef struct {
      logic [COL-1:0] wr;
      logic [BW-1:0]  val;
      logic           rd;
      logic           exp_valid;
      logic           exp_full;
      logic [BW-1:0]  exp_lane;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rep(logic [BW-1:0] v);
      return {COL{v}};
   endfunction

   function automatic logic m_valid();
      for (int k = 0; k < COL; k++)
         if (q[k].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_full();
      for (int k = 0; k < COL; k++)
         if (q[k].size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] m_out();
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < COL; k++)
         if (q[k].size() != 0) r[k*BW +: BW] = q[k][0];
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < COL; k++) q[k].delete();
      m_ovf = '0;
      m_udf = 1'b0;
   endtask

   task automatic model_edge(logic [COL-1:0] w, logic [W-1:0] d, logic r);
      logic v;
      logic racc;
      logic [COL-1:0] acc;
      v    = m_valid();
      racc = r && v;
      for (int k = 0; k < COL; k++)
         acc[k] = w[k] && (q[k].size() < DEPTH || racc);
      if (racc)
         for (int k = 0; k < COL; k++) void'(q[k].pop_front());
      for (int k = 0; k < COL; k++)
         if (acc[k]) q[k].push_back(d[k*BW +: BW]);
      m_ovf = m_ovf | (w & ~acc);
      m_udf = m_udf | (r && !v);
   endtask

   task automatic model_check();
      chk("model.out", out, m_out());
      chk("model.valid", W'(o_valid), W'(m_valid()));
      chk("model.full", W'(o_full), W'(m_full()));
      chk("model.ready", W'(o_ready), W'(!m_full()));
`ifdef OFIFO_STICKY_ERR_EN
      chk("model.ovf", W'(o_ovf), W'(m_ovf));
      chk("model.udf", W'(o_udf), W'(m_udf));
`endif
   endtask

   task automatic step(logic [COL-1:0] w, logic [W-1:0] d, logic r);
      wr = w;
      in = d;
      rd = r;
      @(posedge clk);
      model_edge(w, d, r);
      #1;
      model_check();
      wr = '0;
      rd = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      wr    = '0;
      rd    = 1'b0;
      in    = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", W'(o_valid), W'(0));
      chk("rst.full", W'(o_full), W'(0));
      chk("rst.ready", W'(o_ready), W'(1));
      chk("rst.out", out, '0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [COL-1:0] w;
      logic [W-1:0]   d;

      tbl[0] = '{8'hFF, 16'd1, 1'b0, 1'b1, 1'b0, 16'd1};
      tbl[1] = '{8'hFF, 16'd2, 1'b0, 1'b1, 1'b0, 16'd1};
      tbl[2] = '{8'hFF, 16'd3, 1'b0, 1'b1, 1'b0, 16'd1};
      tbl[3] = '{8'hFF, 16'd4, 1'b0, 1'b1, 1'b1, 16'd1};
      tbl[4] = '{8'hFF, 16'd5, 1'b0, 1'b1, 1'b1, 16'd1};
      tbl[5] = '{8'hFF, 16'd9, 1'b1, 1'b1, 1'b1, 16'd2};
      tbl[6] = '{8'h00, 16'd0, 1'b1, 1'b1, 1'b0, 16'd3};
      tbl[7] = '{8'h00, 16'd0, 1'b1, 1'b1, 1'b0, 16'd4};
      tbl[8] = '{8'h00, 16'd0, 1'b1, 1'b1, 1'b0, 16'd9};
      tbl[9] = '{8'h00, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0};

      do_reset();

      // full, drop, then read+write on a full bank
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].wr, rep(tbl[i].val), tbl[i].rd);
         chk($sformatf("tbl%0d.valid", i), W'(o_valid), W'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d.full", i), W'(o_full), W'(tbl[i].exp_full));
         chk($sformatf("tbl%0d.ready", i), W'(o_ready), W'(!tbl[i].exp_full));
         chk($sformatf("tbl%0d.out", i), out, rep(tbl[i].exp_lane));
`ifdef OFIFO_STICKY_ERR_EN
         if (i == 4) chk("tbl.ovf", W'(o_ovf), W'(8'hFF));
`endif
      end

      // skewed fill
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         w = '0;
         d = '0;
         for (int k = 0; k < COL; k++)
            if (c >= k && c <= k + 3) begin
               w[k] = 1'b1;
               d[k*BW +: BW] = BW'(16*k + c - k);
            end
         step(w, d, 1'b0);
         chk($sformatf("skew.valid%0d", c), W'(o_valid), W'(c >= 7));
      end
      for (int j = 0; j < 4; j++) begin
         d = '0;
         for (int k = 0; k < COL; k++) d[k*BW +: BW] = BW'(16*k + j);
         chk($sformatf("skew.row%0d", j), out, d);
         step('0, '0, 1'b1);
      end
      chk("skew.drained", W'(o_valid), W'(0));

      // underflow: only column 0 has data
      do_reset();
      step(8'h01, W'(16'h55), 1'b0);
      step('0, '0, 1'b1);
      chk("udf.out", out, W'(16'h55));
      chk("udf.valid", W'(o_valid), W'(0));
`ifdef OFIFO_STICKY_ERR_EN
      chk("udf.flag", W'(o_udf), W'(1));
`endif
      step('0, '0, 1'b0);
      chk("udf.out2", out, W'(16'h55));
`ifdef OFIFO_STICKY_ERR_EN
      chk("udf.sticky", W'(o_udf), W'(1));
`endif

      // streaming across several pointer wraps
      do_reset();
      for (int i = 0; i < 20; i++) begin
         d = '0;
         for (int k = 0; k < COL; k++) d[k*BW +: BW] = BW'(i*COL + k + 1);
         step('1, d, 1'b1);
         chk($sformatf("wrap.out%0d", i), out, d);
         chk($sformatf("wrap.valid%0d", i), W'(o_valid), W'(1));
      end

      // asynchronous reset with three rows queued
      do_reset();
      for (int i = 1; i <= 3; i++) step('1, rep(BW'(i)), 1'b0);
      @(posedge clk);
      #3 reset = 1'b0;
      model_clear();
      #1;
      chk("arst.valid", W'(o_valid), W'(0));
      chk("arst.out", out, '0);
      chk("arst.full", W'(o_full), W'(0));
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      step('1, rep(16'hAB), 1'b0);
      chk("arst.first", out, rep(16'hAB));
      step('0, '0, 1'b1);
      chk("arst.empty", W'(o_valid), W'(0));

      // random traffic: fill-biased then drain-biased
      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < COL; k++) d[k*BW +: BW] = BW'($urandom);
         w = COL'($urandom);
         if (i < 200) step(w, d, ($urandom_range(0, 3) == 0));
         else         step(w, d, ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
